a_if_arb: RTL and testbench

Round-robin arbiter and sequencer for the shared counter resource carried by `A_if`: the 32-bit counter (`i`) and its 8-bit view (`w`). It lets up to `NREQ` requesters take turns applying one operation each to the counter: increment, add, load or clear. When no operation is pending, it optionally free-runs the counter by +1 per clock. It sits between the requesting sub-blocks and the interface instance, and is the only driver of the counter.

---
 rtl/a_if_arb.sv | 101 ++++++++++
 tb/tb_a_if_arb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/a_if_arb.sv
// Round-robin arbiter/sequencer for the shared A_if counter: one granted op per
// two cycles (INC/ADD/LOAD/CLEAR), optional +1 free-run when no op lands.
module a_if_arb #(
   parameter int NREQ    = 4,
   parameter int CW      = 32,
   parameter int RST_VAL = 10,
   localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    op,
   input  logic [CW*NREQ-1:0]   wdata,
   input  logic                 run,
   output logic [NREQ-1:0]      gnt,
   output logic [PW-1:0]        owner,
   output logic                 done,
   output logic [CW-1:0]        cnt,
   output logic [7:0]           w
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [1:0] OP_INC = 2'b00, OP_ADD = 2'b01, OP_LOAD = 2'b10;

   state_t          state, state_nx;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   idx;
   logic            found;
   logic            apply;
   logic [1:0]      cur_op;
   logic [CW-1:0]   cur_wd;
   logic [CW-1:0]   cnt_nx;

   // Search starts just after the last grantee so it drops to lowest priority.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (found) state_nx = GRANT;
         GRANT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign cur_op = op[2*int'(owner) +: 2];
   assign cur_wd = wdata[CW*int'(owner) +: CW];
   // A grantee that dropped req during its grant cycle aborts the op.
   assign apply  = (state == GRANT) && req[owner];

   always_comb begin
      cnt_nx = cnt;
      if (apply) begin
         case (cur_op)
            OP_INC:  cnt_nx = cnt + CW'(1);
            OP_ADD:  cnt_nx = cnt + cur_wd;
            OP_LOAD: cnt_nx = cur_wd;
            default: cnt_nx = '0;
         endcase
      end else if (run) begin
         cnt_nx = cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         owner <= '0;
         done  <= 1'b0;
         ptr   <= PW'(NREQ - 1);
         cnt   <= CW'(RST_VAL);
      end else begin
         state <= state_nx;
         done  <= apply;
         cnt   <= cnt_nx;
         gnt   <= '0;
         if (state == IDLE && found) begin
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            owner <= win;
         end
         if (state == GRANT) ptr <= owner;
      end
   end

   assign w = cnt[7:0];

endmodule

// File: tb/tb_a_if_arb.sv
// Directed bench for a_if_arb: reset/free-run, load, round-robin, op vs
// free-run, abort, wrap, and reset in the middle of a grant.
module tb_a_if_arb;

   localparam int NREQ = 4;
   localparam int CW   = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    op;
   logic [CW*NREQ-1:0]   wdata;
   logic                 run;
   logic [NREQ-1:0]      gnt;
   logic [1:0]           owner;
   logic                 done;
   logic [CW-1:0]        cnt;
   logic [7:0]           w;

   int n_run  = 0;
   int n_fail = 0;

   a_if_arb #(.NREQ(NREQ), .CW(CW), .RST_VAL(10)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata), .run(run),
      .gnt(gnt), .owner(owner), .done(done), .cnt(cnt), .w(w)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [1:0] o, input logic [CW-1:0] d);
      req[k]            = 1'b1;
      op[2*k +: 2]      = o;
      wdata[CW*k +: CW] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; op = '0; wdata = '0; run = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; op = '0; wdata = '0; run = 1'b0;

      // Reset and free-run
      run = 1'b1;
      tick(); tick();
      chk("rst_cnt",   cnt,   64'd10);
      chk("rst_w",     w,     64'h0A);
      chk("rst_gnt",   gnt,   64'd0);
      chk("rst_owner", owner, 64'd0);
      chk("rst_done",  done,  64'd0);
      rst = 1'b0;
      tick();
      chk("fr_first", cnt, 64'd11);
      for (int n = 2; n <= 246; n++) begin
         tick();
         if (n == 100) chk("fr_mid_w", w, 64'(8'(10 + n)));
      end
      chk("fr_256", cnt, 64'd256);
      chk("fr_w0",  w,   64'd0);

      // Single LOAD from requester 2
      do_reset();
      tick();
      set_req(2, 2'b10, 32'h1234);
      tick();
      chk("ld_gnt",     gnt,  64'b0100);
      chk("ld_cnt_old", cnt,  64'd10);
      tick();
      req = '0;
      chk("ld_cnt",   cnt,   64'h1234);
      chk("ld_done",  done,  64'd1);
      chk("ld_gnt0",  gnt,   64'd0);
      chk("ld_owner", owner, 64'd2);
      tick();
      chk("ld_done_pulse", done, 64'd0);

      // Round-robin under contention, all INC
      do_reset();
      tick();
      for (int k = 0; k < NREQ; k++) set_req(k, 2'b00, '0);
      for (int g = 0; g < 8; g++) begin
         tick();
         chk($sformatf("rr_gnt%0d", g), gnt, 64'(1 << (g % 4)));
         tick();
         chk($sformatf("rr_cnt%0d", g), cnt, 64'(11 + g));
         chk($sformatf("rr_done%0d", g), done, 64'd1);
      end
      chk("rr_final", cnt, 64'd18);
      req = '0;
      tick();

      // Op versus free-run: LOAD 100, then ADD 5 with run raised in the grant cycle
      do_reset();
      tick();
      set_req(0, 2'b10, 32'd100);
      tick(); tick();
      req = '0;
      chk("ofr_load", cnt, 64'd100);
      set_req(1, 2'b01, 32'd5);
      tick();
      chk("ofr_gnt", gnt, 64'b0010);
      run = 1'b1;
      tick();
      req = '0;
      chk("ofr_add", cnt, 64'd105);
      tick();
      chk("ofr_106", cnt, 64'd106);
      tick();
      chk("ofr_107", cnt, 64'd107);

      // Abort: requester 1 drops req in its grant cycle; 0 and 2 then contend
      do_reset();
      tick();
      set_req(1, 2'b11, '0);
      tick();
      chk("ab_gnt1", gnt, 64'b0010);
      req = '0;
      set_req(0, 2'b00, '0);
      set_req(2, 2'b00, '0);
      tick();
      chk("ab_cnt",  cnt,  64'd10);
      chk("ab_done", done, 64'd0);
      tick();
      chk("ab_next", gnt, 64'b0100);
      tick();
      req = '0;
      chk("ab_inc", cnt, 64'd11);

      // Wrap: LOAD all-ones then INC from requester 0
      tick();
      set_req(0, 2'b10, 32'hFFFF_FFFF);
      tick(); tick();
      chk("wr_load", cnt, 64'hFFFF_FFFF);
      op[1:0] = 2'b00;
      tick();
      chk("wr_gnt", gnt, 64'b0001);
      tick();
      req = '0;
      chk("wr_cnt",  cnt,  64'd0);
      chk("wr_done", done, 64'd1);

      // Reset in the grant cycle of a CLEAR
      tick();
      set_req(2, 2'b11, '0);
      tick();
      chk("mr_gnt", gnt, 64'b0100);
      rst = 1'b1;
      req = '0;
      set_req(3, 2'b00, '0);
      set_req(0, 2'b00, '0);
      tick();
      rst = 1'b0;
      chk("mr_cnt",  cnt,  64'd10);
      chk("mr_gnt0", gnt,  64'd0);
      chk("mr_done", done, 64'd0);
      tick();
      chk("mr_first", gnt, 64'b0001);
      tick();
      chk("mr_inc", cnt, 64'd11);
      req = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
